// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall bundle between the ID-stage pipeline registers and the stall controller.
// master = pipeline side (drives hazard inputs), slave = stall controller (drives control outputs).
interface hazard_stall_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] IF_ID_Rs;
  logic [REG_AW-1:0] IF_ID_Rt;
  logic              IF_ID_UsesRt;
  logic              IF_ID_Branch;
  logic              BranchTaken;
  logic              ID_EX_MemRead;
  logic              ID_EX_RegWrite;
  logic [REG_AW-1:0] ID_EX_RegRd;
  logic              EX_Mem_MemRead;
  logic [REG_AW-1:0] EX_Mem_RegRd;
  logic              PCWrite;
  logic              IF_ID_Write;
  logic              ID_EX_Bubble;
  logic              IF_ID_Flush;
  logic              Stalling;
  logic [CNT_W-1:0]  StallCycles;
  logic [CNT_W-1:0]  FlushCount;

  modport master (
    output IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, IF_ID_Branch, BranchTaken,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_RegRd, EX_Mem_MemRead, EX_Mem_RegRd,
    input  PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Stalling, StallCycles, FlushCount
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, IF_ID_Branch, BranchTaken,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_RegRd, EX_Mem_MemRead, EX_Mem_RegRd,
    output PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Stalling, StallCycles, FlushCount
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// ID-stage load-use / branch-operand stall controller with taken-branch IF/ID flush; counters under HAZARD_PERF_CNT_EN.
// Zero-cycle latency from hazard inputs to stall/flush outputs; a 2-cycle stall holds in HOLD ignoring inputs.
module hazard_stall_unit (
  input  logic              Clk,
  input  logic              Rst_n,
  hazard_stall_unit_if.slave hz
);
  localparam int REG_AW = $bits(hz.IF_ID_Rs);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  remain_q, remain_d;
  logic [1:0]  need_n;
  logic        ex_match, mem_match;
  logic        stall_raw, stall_act, flush_act;

  always_comb begin
    ex_match  = (hz.ID_EX_RegRd != {REG_AW{1'b0}}) &&
                ((hz.ID_EX_RegRd == hz.IF_ID_Rs) ||
                 (hz.IF_ID_UsesRt && (hz.ID_EX_RegRd == hz.IF_ID_Rt)));
    mem_match = (hz.EX_Mem_RegRd != {REG_AW{1'b0}}) &&
                ((hz.EX_Mem_RegRd == hz.IF_ID_Rs) ||
                 (hz.IF_ID_UsesRt && (hz.EX_Mem_RegRd == hz.IF_ID_Rt)));
    need_n = 2'd0;
    if (hz.ID_EX_MemRead && ex_match)
      need_n = 2'd1;
    if (hz.IF_ID_Branch && hz.ID_EX_RegWrite && !hz.ID_EX_MemRead && ex_match)
      need_n = 2'd1;
    if (hz.IF_ID_Branch && hz.EX_Mem_MemRead && mem_match)
      need_n = 2'd1;
    // A load still in EX feeding an ID-resolved branch needs the longest wait.
    if (hz.IF_ID_Branch && hz.ID_EX_MemRead && ex_match)
      need_n = 2'd2;
  end

  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    stall_raw = 1'b0;
    case (state_q)
      IDLE: begin
        remain_d = 2'd0;
        if (need_n != 2'd0) begin
          stall_raw = 1'b1;
          if (need_n == 2'd2) begin
            state_d  = HOLD;
            remain_d = 2'd1;
          end
        end
      end
      HOLD: begin
        stall_raw = 1'b1;
        remain_d  = remain_q - 2'd1;
        if (remain_q == 2'd1) begin
          state_d  = IDLE;
          remain_d = 2'd0;
        end
      end
      default: begin
        state_d  = IDLE;
        remain_d = 2'd0;
      end
    endcase
  end

  // Reset masks the outputs combinationally so the pipeline runs freely while Rst_n is low.
  assign stall_act = Rst_n && stall_raw;
  assign flush_act = Rst_n && hz.IF_ID_Branch && hz.BranchTaken && !stall_act;

  assign hz.PCWrite      = !stall_act;
  assign hz.IF_ID_Write  = !stall_act;
  assign hz.ID_EX_Bubble = stall_act;
  assign hz.Stalling     = stall_act;
  assign hz.IF_ID_Flush  = flush_act;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      remain_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam int CNT_W = $bits(hz.StallCycles);

  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_act && !(&stall_cycles_q))
      stall_cycles_d = stall_cycles_q + 1'b1;
    if (flush_act && !(&flush_count_q))
      flush_count_d = flush_count_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign hz.StallCycles = stall_cycles_q;
  assign hz.FlushCount  = flush_count_q;
`else
  assign hz.StallCycles = '0;
  assign hz.FlushCount  = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: vector table for single-cycle cases, hand sequences for HOLD/reset/counters.
module tb_hazard_stall_unit;
  logic Clk = 1'b0;
  logic Rst_n;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 Clk = ~Clk;

  hazard_stall_unit_if #(.REG_AW(5), .CNT_W(32)) hz ();

  hazard_stall_unit u_dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .hz    (hz.slave)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic       taken;
    logic       ex_mr;
    logic       ex_rw;
    logic [4:0] ex_rd;
    logic       mem_mr;
    logic [4:0] mem_rd;
    logic       exp_stall;
    logic       exp_flush;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                              input logic br, input logic taken, input logic ex_mr, input logic ex_rw,
                              input logic [4:0] ex_rd, input logic mem_mr, input logic [4:0] mem_rd,
                              input logic exp_stall, input logic exp_flush);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.br = br; v.taken = taken;
    v.ex_mr = ex_mr; v.ex_rw = ex_rw; v.ex_rd = ex_rd; v.mem_mr = mem_mr; v.mem_rd = mem_rd;
    v.exp_stall = exp_stall; v.exp_flush = exp_flush;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    hz.IF_ID_Rs       = v.rs;
    hz.IF_ID_Rt       = v.rt;
    hz.IF_ID_UsesRt   = v.uses_rt;
    hz.IF_ID_Branch   = v.br;
    hz.BranchTaken    = v.taken;
    hz.ID_EX_MemRead  = v.ex_mr;
    hz.ID_EX_RegWrite = v.ex_rw;
    hz.ID_EX_RegRd    = v.ex_rd;
    hz.EX_Mem_MemRead = v.mem_mr;
    hz.EX_Mem_RegRd   = v.mem_rd;
  endtask

  task automatic clear_in();
    apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packed as {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Stalling}.
  task automatic chk_out(input string name, input logic s, input logic f);
    logic [4:0] act;
    logic [4:0] exp;
    act = {hz.PCWrite, hz.IF_ID_Write, hz.ID_EX_Bubble, hz.IF_ID_Flush, hz.Stalling};
    exp = {~s, ~s, s, f, s};
    chk(name, {27'd0, act}, {27'd0, exp});
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  vec_t lu_v, bl2_v, br_v;
  logic [31:0] exp_stall_cnt, exp_flush_cnt;

  initial begin
    //            rs     rt    ur  br  tk  exmr exrw exrd  mmr  mrd   stall flush
    vecs[0]  = mk(5'd8, 5'd0, 0, 0, 0, 1, 1, 5'd8, 0, 5'd0, 1, 0);  // load-use on Rs
    vecs[1]  = mk(5'd8, 5'd0, 0, 0, 0, 0, 0, 5'd0, 1, 5'd8, 0, 0);  // bubble in EX, load in MEM, no branch
    vecs[2]  = mk(5'd0, 5'd0, 0, 0, 0, 1, 1, 5'd0, 0, 5'd0, 0, 0);  // r0 never hazards
    vecs[3]  = mk(5'd3, 5'd9, 0, 0, 0, 1, 1, 5'd9, 0, 5'd0, 0, 0);  // Rt unused
    vecs[4]  = mk(5'd3, 5'd9, 1, 0, 0, 1, 1, 5'd9, 0, 5'd0, 1, 0);  // Rt used
    vecs[5]  = mk(5'd4, 5'd0, 0, 1, 1, 0, 1, 5'd4, 0, 5'd0, 1, 0);  // branch on ALU result, stall beats flush
    vecs[6]  = mk(5'd4, 5'd0, 0, 0, 1, 0, 1, 5'd4, 0, 5'd0, 0, 0);  // ALU dep, not a branch
    vecs[7]  = mk(5'd2, 5'd7, 1, 1, 0, 0, 0, 5'd0, 1, 5'd7, 1, 0);  // branch on load in MEM via Rt
    vecs[8]  = mk(5'd0, 5'd0, 1, 1, 1, 0, 0, 5'd0, 1, 5'd0, 0, 1);  // MEM load to r0, taken
    vecs[9]  = mk(5'd1, 5'd2, 1, 1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 1);  // taken branch, no hazard
    vecs[10] = mk(5'd1, 5'd2, 1, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 0);  // BranchTaken without branch
    vecs[11] = mk(5'd5, 5'd6, 0, 1, 1, 0, 1, 5'd6, 0, 5'd0, 0, 1);  // EX rd only on unused Rt
    vecs[12] = mk(5'd5, 5'd6, 1, 1, 0, 0, 0, 5'd0, 1, 5'd6, 1, 0);  // MEM load on used Rt
    lu_v  = mk(5'd8, 5'd0, 0, 0, 0, 1, 1, 5'd8, 0, 5'd0, 1, 0);
    bl2_v = mk(5'd5, 5'd0, 0, 1, 1, 1, 1, 5'd5, 0, 5'd0, 1, 0);
    br_v  = mk(5'd1, 5'd2, 1, 1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 1);

    // Reset masks outputs even with a hazard and taken branch present
    Rst_n = 1'b0;
    apply(bl2_v);
    #2;
    chk_out("reset_masks_outputs", 1'b0, 1'b0);
    chk("reset_stall_cnt", hz.StallCycles, 32'd0);
    chk("reset_flush_cnt", hz.FlushCount, 32'd0);
    step();
    clear_in();
    Rst_n = 1'b1;
    #1;
    chk_out("post_reset_idle", 1'b0, 1'b0);
    step();

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp_flush);
      step();
    end
    clear_in();
    step();

    // Branch on load in EX: exactly two stall cycles, then the flush
    apply(bl2_v);
    #1;
    chk_out("bl2_cycle1", 1'b1, 1'b0);
    step();
    chk_out("bl2_cycle2_hold", 1'b1, 1'b0);
    step();
    apply(br_v);
    #1;
    chk_out("bl2_after_flush", 1'b0, 1'b1);
    step();
    clear_in();
    #1;
    chk_out("bl2_quiet", 1'b0, 1'b0);
    step();

    // HOLD ignores input changes
    apply(bl2_v);
    #1;
    chk_out("hold_ign_c1", 1'b1, 1'b0);
    step();
    clear_in();
    #1;
    chk_out("hold_ign_c2", 1'b1, 1'b0);
    step();
    chk_out("hold_ign_idle", 1'b0, 1'b0);
    step();

    // Reset during HOLD abandons the stall
    apply(bl2_v);
    step();
    chk_out("rst_hold_in_hold", 1'b1, 1'b0);
    #1;
    Rst_n = 1'b0;
    #1;
    chk_out("rst_hold_async", 1'b0, 1'b0);
    step();
    clear_in();
    Rst_n = 1'b1;
    #1;
    chk_out("rst_hold_release", 1'b0, 1'b0);
    step();
    chk_out("rst_hold_idle", 1'b0, 1'b0);
    apply(lu_v);
    #1;
    chk_out("rst_hold_lu", 1'b1, 1'b0);
    step();
    clear_in();
    #1;
    chk_out("rst_hold_lu_single", 1'b0, 1'b0);
    step();

    // Counters: 3 single-cycle load-use stalls, 2 taken branches
    Rst_n = 1'b0;
    #2;
    Rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      apply(lu_v);
      step();
      clear_in();
      step();
    end
    for (int i = 0; i < 2; i++) begin
      apply(br_v);
      step();
      clear_in();
      step();
    end
`ifdef HAZARD_PERF_CNT_EN
    exp_stall_cnt = 32'd3;
    exp_flush_cnt = 32'd2;
`else
    exp_stall_cnt = 32'd0;
    exp_flush_cnt = 32'd0;
`endif
    chk("stall_cycles", hz.StallCycles, exp_stall_cnt);
    chk("flush_count", hz.FlushCount, exp_flush_cnt);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
